// File: rtl/mem_wb_stage_if.sv
// Interface bundling the memory/write-back stage signals.
//   Upstream bundle : stage4in, pc, ir, data, addr      (execute stage -> this stage)
//   Memory port     : mem_addr, mem_wdata, mem_rd, mem_we (stage -> memory),
//                     mem_rdata, mem_ack                  (memory -> stage)
//   Write-back      : reg_we, reg_waddr, reg_wdata        (stage -> register file)
//   Redirect        : br_valid, br_taken, br_target       (stage -> fetch)
//   Status          : busy, mem_err                       (stage -> pipeline control)
// The stage connects through the slave modport; its environment uses master.
interface mem_wb_stage_if #(
   parameter int unsigned DataW = 16,
   parameter int unsigned RegAw = 4
);
   logic             stage4in;
   logic [DataW-1:0] pc;
   logic [DataW-1:0] ir;
   logic [DataW-1:0] data;
   logic [DataW-1:0] addr;

   logic [DataW-1:0] mem_rdata;
   logic             mem_ack;
   logic [DataW-1:0] mem_addr;
   logic [DataW-1:0] mem_wdata;
   logic             mem_rd;
   logic             mem_we;

   logic             reg_we;
   logic [RegAw-1:0] reg_waddr;
   logic [DataW-1:0] reg_wdata;

   logic             br_valid;
   logic             br_taken;
   logic [DataW-1:0] br_target;

   logic             busy;
   logic             mem_err;

   modport slave (
      input  stage4in, pc, ir, data, addr, mem_rdata, mem_ack,
      output mem_addr, mem_wdata, mem_rd, mem_we,
      output reg_we, reg_waddr, reg_wdata,
      output br_valid, br_taken, br_target,
      output busy, mem_err
   );

   modport master (
      output stage4in, pc, ir, data, addr, mem_rdata, mem_ack,
      input  mem_addr, mem_wdata, mem_rd, mem_we,
      input  reg_we, reg_waddr, reg_wdata,
      input  br_valid, br_taken, br_target,
      input  busy, mem_err
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory / write-back stage (4/5) of the 16-bit CPU.
// Captures one executed instruction per stage4in strobe while idle and performs its side
// effect: a data-memory read or write over a req/ack handshake, a register write-back, or a
// branch/jump redirect. busy holds the upstream stages while the stage is occupied.
// Ports:
//   clk_i   - clock, all state changes on the rising edge
//   rst_i   - asynchronous, active-high reset
//   bus_io  - mem_wb_stage_if slave modport (bundle in, memory port, write-back, redirect,
//             busy, sticky mem_err)
// Instruction fields: op = ir[15:12], destination register = ir[11:8].
// All outputs are decoded from the state register and latched bundle only.
module mem_wb_stage #(
   parameter int unsigned DataW      = 16,
   parameter int unsigned RegAw      = 4,
   parameter int unsigned MemTimeout = 15
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   mem_wb_stage_if.slave         bus_io
);

   localparam int unsigned OpW  = 4;
   localparam int unsigned CntW = $clog2(MemTimeout + 1);

   localparam logic [OpW-1:0] OpAdd  = 4'h1;
   localparam logic [OpW-1:0] OpSub  = 4'h2;
   localparam logic [OpW-1:0] OpSlt  = 4'h3;
   localparam logic [OpW-1:0] OpAnd  = 4'h4;
   localparam logic [OpW-1:0] OpOr   = 4'h5;
   localparam logic [OpW-1:0] OpAddi = 4'h6;
   localparam logic [OpW-1:0] OpLw   = 4'h7;
   localparam logic [OpW-1:0] OpSw   = 4'h8;
   localparam logic [OpW-1:0] OpBeq  = 4'h9;
   localparam logic [OpW-1:0] OpJump = 4'hA;

   typedef enum logic [2:0] {StIdle, StRd, StWr, StWb, StBr} state_e;

   state_e           state_q, state_d;
   logic [OpW-1:0]   op_q, op_d;
   logic [RegAw-1:0] rd_q, rd_d;
   logic [DataW-1:0] data_q, data_d;
   logic [DataW-1:0] addr_q, addr_d;
   logic [DataW-1:0] rdata_q, rdata_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [OpW-1:0]   op_in;
   logic [RegAw-1:0] rd_in;

   logic [DataW-1:0] mem_addr, mem_wdata, reg_wdata, br_target;
   logic [RegAw-1:0] reg_waddr;
   logic             mem_rd, mem_we, reg_we, br_valid, br_taken;

   assign op_in = bus_io.ir[DataW-1 -: OpW];
   assign rd_in = bus_io.ir[RegAw+7:8];

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      data_d    = data_q;
      addr_d    = addr_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      reg_waddr = '0;
      reg_wdata = '0;
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.stage4in) begin
               op_d   = op_in;
               rd_d   = rd_in;
               data_d = bus_io.data;
               addr_d = bus_io.addr;
               cnt_d  = '0;
               case (op_in)
                  OpLw:                                    state_d = StRd;
                  OpSw:                                    state_d = StWr;
                  OpAdd, OpSub, OpSlt, OpAnd, OpOr, OpAddi: state_d = StWb;
                  OpBeq, OpJump:                           state_d = StBr;
                  default:                                 state_d = StIdle;
               endcase
            end
         end
         StRd: begin
            mem_rd   = 1'b1;
            mem_addr = addr_q;
            // An ack arriving on the expiry cycle still wins over the timeout.
            if (bus_io.mem_ack) begin
               rdata_d = bus_io.mem_rdata;
               state_d = StWb;
            end else if (cnt_q == CntW'(MemTimeout - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWr: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = data_q;
            if (bus_io.mem_ack) begin
               state_d = StIdle;
            end else if (cnt_q == CntW'(MemTimeout - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWb: begin
            reg_we    = 1'b1;
            reg_waddr = rd_q;
            reg_wdata = (op_q == OpLw) ? rdata_q : data_q;
            state_d   = StIdle;
         end
         StBr: begin
            br_valid = 1'b1;
            if (op_q == OpBeq) begin
               // Execute stage reports the BEQ compare as all-ones when equal.
               br_taken  = (data_q == {DataW{1'b1}});
               br_target = addr_q;
            end else begin
               br_taken  = 1'b1;
               br_target = data_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         op_q    <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign bus_io.mem_addr  = mem_addr;
   assign bus_io.mem_wdata = mem_wdata;
   assign bus_io.mem_rd    = mem_rd;
   assign bus_io.mem_we    = mem_we;
   assign bus_io.reg_we    = reg_we;
   assign bus_io.reg_waddr = reg_waddr;
   assign bus_io.reg_wdata = reg_wdata;
   assign bus_io.br_valid  = br_valid;
   assign bus_io.br_taken  = br_taken;
   assign bus_io.br_target = br_target;
   assign bus_io.busy      = (state_q != StIdle);
   assign bus_io.mem_err   = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU write-back, load/store handshakes, branches,
// timeout handling and asynchronous reset during an access.
module tb_mem_wb_stage;

   localparam logic [3:0] OpAdd  = 4'h1;
   localparam logic [3:0] OpAddi = 4'h6;
   localparam logic [3:0] OpLw   = 4'h7;
   localparam logic [3:0] OpSw   = 4'h8;
   localparam logic [3:0] OpBeq  = 4'h9;
   localparam logic [3:0] OpJump = 4'hA;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   cnt;

   mem_wb_stage_if #(.DataW(16), .RegAw(4)) bus ();

   mem_wb_stage #(.DataW(16), .RegAw(4), .MemTimeout(15)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] d,
                        input logic [15:0] a);
      bus.ir       = {op, rd, 8'h00};
      bus.data     = d;
      bus.addr     = a;
      bus.stage4in = 1'b1;
      step();
      bus.stage4in = 1'b0;
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b1;
      bus.stage4in  = 1'b0;
      bus.pc        = 16'h0000;
      bus.ir        = 16'h0000;
      bus.data      = 16'h0000;
      bus.addr      = 16'h0000;
      bus.mem_rdata = 16'h0000;
      bus.mem_ack   = 1'b0;
      step();
      step();
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_mem_rd", bus.mem_rd, 0);
      check_eq("rst_mem_we", bus.mem_we, 0);
      check_eq("rst_reg_we", bus.reg_we, 0);
      check_eq("rst_br_valid", bus.br_valid, 0);
      check_eq("rst_mem_err", bus.mem_err, 0);
      rst = 1'b0;

      // Stray ack in idle does nothing.
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      check_eq("idle_ack_busy", bus.busy, 0);

      // ALU op: one write-back cycle.
      bus.pc = 16'h0100;
      issue(OpAdd, 4'd3, 16'h1234, 16'h0000);
      check_eq("add_reg_we", bus.reg_we, 1);
      check_eq("add_waddr", bus.reg_waddr, 3);
      check_eq("add_wdata", bus.reg_wdata, 16'h1234);
      check_eq("add_busy", bus.busy, 1);
      step();
      check_eq("add_busy_end", bus.busy, 0);
      check_eq("add_reg_we_end", bus.reg_we, 0);

      // Write to r0 is not suppressed.
      issue(OpAddi, 4'd0, 16'h0007, 16'h0000);
      check_eq("r0_reg_we", bus.reg_we, 1);
      check_eq("r0_wdata", bus.reg_wdata, 16'h0007);
      step();

      // LW: ack on the third request cycle.
      issue(OpLw, 4'd5, 16'h0000, 16'h0040);
      for (int i = 0; i < 3; i++) begin
         check_eq("lw_mem_rd", bus.mem_rd, 1);
         check_eq("lw_mem_addr", bus.mem_addr, 16'h0040);
         check_eq("lw_no_reg_we", bus.reg_we, 0);
         if (i == 2) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 16'hBEEF;
         end
         step();
         bus.mem_ack = 1'b0;
      end
      check_eq("lw_rd_drop", bus.mem_rd, 0);
      check_eq("lw_reg_we", bus.reg_we, 1);
      check_eq("lw_waddr", bus.reg_waddr, 5);
      check_eq("lw_wdata", bus.reg_wdata, 16'hBEEF);
      step();
      check_eq("lw_busy_end", bus.busy, 0);

      // SW with stage4in held while busy: exactly one write.
      bus.ir       = {OpSw, 4'd2, 8'h00};
      bus.data     = 16'h00AA;
      bus.addr     = 16'h0010;
      bus.stage4in = 1'b1;
      step();
      cnt = 0;
      for (int i = 0; i < 2; i++) begin
         if (bus.mem_we) cnt++;
         check_eq("sw_addr", bus.mem_addr, 16'h0010);
         check_eq("sw_wdata", bus.mem_wdata, 16'h00AA);
         check_eq("sw_no_reg_we", bus.reg_we, 0);
         if (i == 1) bus.mem_ack = 1'b1;
         step();
         bus.mem_ack = 1'b0;
      end
      bus.stage4in = 1'b0;
      check_eq("sw_we_cycles", cnt, 2);
      check_eq("sw_we_drop", bus.mem_we, 0);
      check_eq("sw_busy_end", bus.busy, 0);
      step();
      check_eq("sw_no_rewrite", bus.mem_we, 0);
      check_eq("sw_no_reg_we_end", bus.reg_we, 0);

      // Branches.
      issue(OpBeq, 4'd0, 16'hFFFF, 16'h0020);
      check_eq("beq_t_valid", bus.br_valid, 1);
      check_eq("beq_t_taken", bus.br_taken, 1);
      check_eq("beq_t_target", bus.br_target, 16'h0020);
      step();
      check_eq("beq_t_valid_end", bus.br_valid, 0);
      issue(OpBeq, 4'd0, 16'h0000, 16'h0020);
      check_eq("beq_n_valid", bus.br_valid, 1);
      check_eq("beq_n_taken", bus.br_taken, 0);
      step();
      issue(OpJump, 4'd0, 16'h0123, 16'h0456);
      check_eq("jmp_valid", bus.br_valid, 1);
      check_eq("jmp_taken", bus.br_taken, 1);
      check_eq("jmp_target", bus.br_target, 16'h0123);
      step();

      // Ack on the final (15th) cycle still succeeds.
      issue(OpLw, 4'd9, 16'h0000, 16'h0050);
      for (int i = 0; i < 15; i++) begin
         check_eq("lwx_mem_rd", bus.mem_rd, 1);
         if (i == 14) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 16'h0F0F;
         end
         step();
         bus.mem_ack = 1'b0;
      end
      check_eq("lwx_reg_we", bus.reg_we, 1);
      check_eq("lwx_wdata", bus.reg_wdata, 16'h0F0F);
      check_eq("lwx_no_err", bus.mem_err, 0);
      step();

      // LW timeout: 15 request cycles, sticky error, no write-back.
      issue(OpLw, 4'd4, 16'h0000, 16'h0060);
      cnt = 0;
      while (bus.mem_rd && cnt < 40) begin
         check_eq("to_no_reg_we", bus.reg_we, 0);
         cnt++;
         step();
      end
      check_eq("to_rd_cycles", cnt, 15);
      check_eq("to_mem_err", bus.mem_err, 1);
      check_eq("to_busy", bus.busy, 0);
      check_eq("to_no_reg_we_end", bus.reg_we, 0);
      step();
      check_eq("to_err_sticky", bus.mem_err, 1);
      issue(OpAdd, 4'd7, 16'h5555, 16'h0000);
      check_eq("post_to_reg_we", bus.reg_we, 1);
      check_eq("post_to_waddr", bus.reg_waddr, 7);
      check_eq("post_to_wdata", bus.reg_wdata, 16'h5555);
      check_eq("post_to_err", bus.mem_err, 1);
      step();

      // Reset in the middle of a store.
      issue(OpSw, 4'd0, 16'h0077, 16'h0030);
      check_eq("rsw_mem_we", bus.mem_we, 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rsw_we_async", bus.mem_we, 0);
      check_eq("rsw_addr_async", bus.mem_addr, 0);
      check_eq("rsw_busy_async", bus.busy, 0);
      check_eq("rsw_err_async", bus.mem_err, 0);
      step();
      rst = 1'b0;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      check_eq("late_ack_busy", bus.busy, 0);
      check_eq("late_ack_we", bus.mem_we, 0);
      check_eq("late_ack_reg_we", bus.reg_we, 0);

      // Bubble and undefined op stay idle.
      bus.ir       = 16'h0000;
      bus.stage4in = 1'b1;
      step();
      bus.stage4in = 1'b0;
      check_eq("bubble_busy", bus.busy, 0);
      check_eq("bubble_reg_we", bus.reg_we, 0);
      check_eq("bubble_br", bus.br_valid, 0);
      issue(4'hF, 4'd1, 16'h1111, 16'h2222);
      check_eq("undef_busy", bus.busy, 0);
      check_eq("undef_rd", bus.mem_rd, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
